sisc_fetch_unit: RTL and testbench
==================================

# sisc_fetch_unit

Instruction-side datapath partner of the SISC control FSM. It holds the program counter (PC) and instruction register (IR), and fetches instruction words from instruction memory over a request/valid handshake. It drives the decoded fields (opcode, mm, register indices, immediate) into the controller and applies the PC update for the branch instructions. It accepts the controller's `ir_load` / `pc_write` strobes and answers with `fetch_done` / `br_taken`.

## Interface
- `ADDR_W`, 16: PC and instruction-memory address width.
- `DATA_W`, 32: instruction word width; fixed format described under Operation.
- `clk`  in  1: single clock, all state on rising edge.
- `rst_f`  in  1: synchronous, active-high reset.
- `ir_load`  in  1: controller strobe that starts a fetch at the current PC.
- `pc_write`  in  1: controller strobe that resolves a branch for the instruction held in IR.
- `stat`  in  4: status flags from the ALU status register.
- `im_req`  out  1: instruction memory request, held until accepted.
- `im_addr`  out  ADDR_W: fetch address, equal to the PC while `im_req` is high.
- `im_rdata`  in  DATA_W: instruction word, valid with `im_valid`.
- `im_valid`  in  1: memory response; meaningful only while `im_req` is high.
- `fetch_done`  out  1: one-cycle pulse marking that the IR has been updated.
- `br_taken`  out  1: one-cycle pulse marking that a branch redirected the PC.
- `busy`  out  1: high while a fetch is outstanding.
- `halted`  out  1: halt indication (see Configuration).
- `pc`  out  ADDR_W: current PC.
- `opcode`  out  4: IR[31:28].
- `mm`  out  4: IR[27:24].
- `rd`  out  4: IR[23:20].
- `rs`  out  4: IR[19:16].
- `rt`  out  4: IR[15:12].
- `imm`  out  16: IR[15:0].

## Operation
- Field outputs are combinational slices of the IR. They are stable between fetches.
- FSM states:
  - IDLE: waits for `ir_load`; `busy`=0.
  - BUSY: `im_req`=1, `im_addr`=`pc`; stays in BUSY until `im_valid`=1.
  - HALT: exists only with the macro; see Configuration.
- IDLE→BUSY on `ir_load`.
- BUSY→IDLE on `im_valid`, with these actions:
  - IR ← `im_rdata`.
  - PC ← PC+1, modulo 2^ADDR_W; 0xFFFF wraps to 0x0000.
  - `fetch_done` pulses the next cycle.
- `ir_load` is ignored while in BUSY. `pc_write` is ignored while in BUSY.
- `im_valid` received while in IDLE is ignored. This covers stale responses after a reset.
- Branch resolution happens on `pc_write` in IDLE. The PC used is the already-incremented PC. Let `cond` = `(stat & mm) != 0`.
  - BRA (4): if `cond`, PC ← `imm`.
  - BRR (5): if `cond`, PC ← PC + sign-extended `imm`, truncated to ADDR_W (wraps).
  - BNE (6): if `!cond`, PC ← `imm`.
  - Any other opcode: PC unchanged, `br_taken`=0.
  - `br_taken` pulses the cycle after a taken branch.
- `pc_write` and `ir_load` in the same IDLE cycle: the PC update is applied first. The fetch then enters BUSY with `im_addr` equal to the updated PC.
- Reset, including mid-fetch, forces:
  - state = IDLE;
  - PC = 0, IR = 0;
  - `im_req`, `fetch_done`, `br_taken`, `busy`, `halted` = 0;
  - `im_addr` = 0, all field outputs = 0.

## Timing
- `ir_load` is sampled in cycle 0. `im_req` is high from cycle 1.
- With zero-wait memory (`im_valid` in cycle 1): IR, PC+1 and `fetch_done` are all visible in cycle 2. Minimum fetch latency is 2 cycles from `ir_load`.
- With a memory that takes N wait cycles, `fetch_done` appears in cycle 2+N.
- A branch's PC update is visible the cycle after `pc_write`, with `br_taken` in that same cycle.
- `im_req` deasserts in the cycle after `im_valid`. The memory must not assert `im_valid` twice for one request.

## Configuration
- `SISC_HALT_DETECT_EN` defined:
  - An IR load with opcode 15 (HLT) moves the FSM to HALT. `halted`=1 from the `fetch_done` cycle.
  - In HALT, `ir_load` and `pc_write` are ignored. Only `rst_f` leaves HALT.
- Not defined: HLT is fetched like any other word, `halted` is tied to 0, and the HALT state does not exist.

## Structure
- Shared package `sisc_pkg` holds:
  - opcode constants NOOP, LOD, STR, BRA, BRR, BNE, ALU_OP, HLT;
  - the IR field bit positions;
  - the fetch-state enum.
- The controller uses the same package.
- One sub-module, `sisc_br_resolve`: combinational branch target/taken logic. Inputs are opcode, mm, stat, pc, imm; outputs are next_pc and taken.

## Test plan
- Reset, then `ir_load` with memory returning 0x8123_4000 with zero wait → `im_addr`=0x0000 in cycle 1; cycle 2 shows `opcode`=8, `mm`=1, `rd`=2, `pc`=0x0001, `fetch_done`=1.
- Memory with 3 wait cycles, plus an extra `ir_load` pulse mid-fetch → `fetch_done` in cycle 5 only, exactly one request.
- IR=BRR with `imm`=0xFFFE, `mm`=4'b0001, `stat`=4'b0001, PC=0x0010, `pc_write` → PC=0x000E, `br_taken`=1. The same case with `stat`=0 → PC=0x0010, `br_taken`=0.
- IR=BNE with `imm`=0x0040, `mm`=4'b0001, `stat`=0, with `pc_write` and `ir_load` in the same cycle → `im_addr`=0x0040 on the following request.
- PC=0xFFFF fetch → PC=0x0000 after `fetch_done`.
- Assert `rst_f` during BUSY, then inject `im_valid` in IDLE → IR stays 0, PC stays 0, no `fetch_done`. With `SISC_HALT_DETECT_EN`, fetch 0xF000_0000 → `halted`=1, and subsequent `ir_load` produces no `im_req`.

Source files
------------

// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcodes, IR field positions, fetch-state encoding.
// SISC_HALT_DETECT_EN adds the HALT fetch state.
package sisc_pkg;

  localparam logic [3:0] NOOP   = 4'd0;
  localparam logic [3:0] LOD    = 4'd1;
  localparam logic [3:0] STR    = 4'd2;
  localparam logic [3:0] BRA    = 4'd4;
  localparam logic [3:0] BRR    = 4'd5;
  localparam logic [3:0] BNE    = 4'd6;
  localparam logic [3:0] ALU_OP = 4'd8;
  localparam logic [3:0] HLT    = 4'd15;

  localparam int unsigned OPC_LO  = 28;
  localparam int unsigned MM_LO   = 24;
  localparam int unsigned RD_LO   = 20;
  localparam int unsigned RS_LO   = 16;
  localparam int unsigned RT_LO   = 12;
  localparam int unsigned IMM_LO  = 0;
  localparam int unsigned FIELD_W = 4;
  localparam int unsigned IMM_W   = 16;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_BUSY = 2'd1
`ifdef SISC_HALT_DETECT_EN
    , FS_HALT = 2'd2
`endif
  } fetch_state_t;

endpackage

// File: rtl/sisc_br_resolve.sv
// Combinational branch resolution: decides whether a BRA/BRR/BNE is taken
// and produces the redirected PC.
module sisc_br_resolve
  import sisc_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic [3:0]        opcode,
  input  logic [3:0]        mm,
  input  logic [3:0]        stat,
  input  logic [ADDR_W-1:0] pc,
  input  logic [15:0]       imm,
  output logic [ADDR_W-1:0] next_pc,
  output logic              taken
);

  logic              w_cond;
  logic [ADDR_W-1:0] w_imm_zx;
  logic [ADDR_W-1:0] w_imm_sx;

  assign w_cond   = |(stat & mm);
  assign w_imm_zx = ADDR_W'(imm);
  assign w_imm_sx = ADDR_W'($signed(imm));

  always_comb begin
    next_pc = pc;
    taken   = 1'b0;
    case (opcode)
      BRA: if (w_cond) begin
        next_pc = w_imm_zx;
        taken   = 1'b1;
      end
      BRR: if (w_cond) begin
        next_pc = pc + w_imm_sx;
        taken   = 1'b1;
      end
      BNE: if (!w_cond) begin
        next_pc = w_imm_zx;
        taken   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sisc_fetch_unit.sv
// SISC instruction fetch: PC/IR ownership, memory handshake, branch PC update.
// SISC_HALT_DETECT_EN enables HLT detection and the HALT state.
module sisc_fetch_unit
  import sisc_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              ir_load,
  input  logic              pc_write,
  input  logic [3:0]        stat,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [DATA_W-1:0] im_rdata,
  input  logic              im_valid,
  output logic              fetch_done,
  output logic              br_taken,
  output logic              busy,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        opcode,
  output logic [3:0]        mm,
  output logic [3:0]        rd,
  output logic [3:0]        rs,
  output logic [3:0]        rt,
  output logic [15:0]       imm
);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic              r_fetch_done;
  logic              r_br_taken;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_taken;

  assign opcode = r_ir[OPC_LO +: FIELD_W];
  assign mm     = r_ir[MM_LO  +: FIELD_W];
  assign rd     = r_ir[RD_LO  +: FIELD_W];
  assign rs     = r_ir[RS_LO  +: FIELD_W];
  assign rt     = r_ir[RT_LO  +: FIELD_W];
  assign imm    = r_ir[IMM_LO +: IMM_W];

  sisc_br_resolve #(.ADDR_W(ADDR_W)) u_br_resolve (
    .opcode  (opcode),
    .mm      (mm),
    .stat    (stat),
    .pc      (r_pc),
    .imm     (imm),
    .next_pc (w_next_pc),
    .taken   (w_taken)
  );

`ifdef SISC_HALT_DETECT_EN
  logic r_halted;
  assign halted = r_halted;
`else
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst_f) begin
      r_state      <= FS_IDLE;
      r_pc         <= '0;
      r_ir         <= '0;
      r_fetch_done <= 1'b0;
      r_br_taken   <= 1'b0;
`ifdef SISC_HALT_DETECT_EN
      r_halted     <= 1'b0;
`endif
    end else begin
      r_fetch_done <= 1'b0;
      r_br_taken   <= 1'b0;
      case (r_state)
        // Branch update lands at this edge, so a same-cycle fetch requests the new PC.
        FS_IDLE: begin
          if (pc_write && w_taken) begin
            r_pc       <= w_next_pc;
            r_br_taken <= 1'b1;
          end
          if (ir_load) r_state <= FS_BUSY;
        end
        FS_BUSY: begin
          if (im_valid) begin
            r_ir         <= im_rdata;
            r_pc         <= r_pc + ADDR_W'(1);
            r_fetch_done <= 1'b1;
`ifdef SISC_HALT_DETECT_EN
            if (im_rdata[OPC_LO +: FIELD_W] == HLT) begin
              r_state  <= FS_HALT;
              r_halted <= 1'b1;
            end else begin
              r_state  <= FS_IDLE;
            end
`else
            r_state <= FS_IDLE;
`endif
          end
        end
`ifdef SISC_HALT_DETECT_EN
        FS_HALT: ;
`endif
        default: r_state <= FS_IDLE;
      endcase
    end
  end

  assign im_req     = (r_state == FS_BUSY);
  assign busy       = im_req;
  assign im_addr    = im_req ? r_pc : '0;
  assign pc         = r_pc;
  assign fetch_done = r_fetch_done;
  assign br_taken   = r_br_taken;

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Directed bench for sisc_fetch_unit: vector table plus multi-cycle sequences.
module tb_sisc_fetch_unit;

  logic        clk;
  logic        rst_f;
  logic        ir_load;
  logic        pc_write;
  logic [3:0]  stat;
  logic        im_req;
  logic [15:0] im_addr;
  logic [31:0] im_rdata;
  logic        im_valid;
  logic        fetch_done;
  logic        br_taken;
  logic        busy;
  logic        halted;
  logic [15:0] pc;
  logic [3:0]  opcode, mm, rd, rs, rt;
  logic [15:0] imm;

  sisc_fetch_unit #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .ir_load    (ir_load),
    .pc_write   (pc_write),
    .stat       (stat),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .im_rdata   (im_rdata),
    .im_valid   (im_valid),
    .fetch_done (fetch_done),
    .br_taken   (br_taken),
    .busy       (busy),
    .halted     (halted),
    .pc         (pc),
    .opcode     (opcode),
    .mm         (mm),
    .rd         (rd),
    .rs         (rs),
    .rt         (rt),
    .imm        (imm)
  );

  typedef struct {
    logic        il, pw, v;
    logic [3:0]  st;
    logic [31:0] rdata;
    logic        req, by, fd, bt;
    logic [15:0] addr, p;
    logic [31:0] ir;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];
  int   n_vec = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mkv(input logic il, pw, v, input logic [3:0] st,
                               input logic [31:0] rdata, input logic req, by, fd, bt,
                               input logic [15:0] addr, p, input logic [31:0] ir);
    vec_t r;
    r.il = il; r.pw = pw; r.v = v; r.st = st; r.rdata = rdata;
    r.req = req; r.by = by; r.fd = fd; r.bt = bt;
    r.addr = addr; r.p = p; r.ir = ir;
    return r;
  endfunction

  function automatic logic [72:0] obs();
    return {im_req, busy, fetch_done, br_taken, halted, im_addr, pc,
            opcode, mm, rd, rs, imm, rt};
  endfunction

  function automatic logic [72:0] expv(input vec_t e);
    logic [31:0] ir;
    ir = e.ir;
    return {e.req, e.by, e.fd, e.bt, 1'b0, e.addr, e.p, ir, ir[15:12]};
  endfunction

  task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ir_load = 1'b0; pc_write = 1'b0; im_valid = 1'b0; stat = 4'h0; im_rdata = 32'h0;
  endtask

  initial begin
    int reqs;
    logic prev_req;

    //              il    pw    v     st     rdata          req   by    fd    bt    addr      pc        ir
    vecs[0]  = mkv(1'b1, 1'b0, 1'b0, 4'h0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 32'h0);
    vecs[1]  = mkv(1'b0, 1'b0, 1'b1, 4'h0, 32'h8123_4000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0001, 32'h8123_4000);
    vecs[2]  = mkv(1'b0, 1'b0, 1'b0, 4'h0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 32'h8123_4000);
    vecs[3]  = mkv(1'b1, 1'b0, 1'b0, 4'h0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 16'h0001, 32'h8123_4000);
    vecs[4]  = mkv(1'b0, 1'b0, 1'b1, 4'h0, 32'h4F00_000F, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0002, 32'h4F00_000F);
    vecs[5]  = mkv(1'b0, 1'b1, 1'b0, 4'h1, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h000F, 32'h4F00_000F);
    vecs[6]  = mkv(1'b1, 1'b0, 1'b0, 4'h0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 16'h000F, 16'h000F, 32'h4F00_000F);
    vecs[7]  = mkv(1'b0, 1'b0, 1'b1, 4'h0, 32'h5100_FFFE, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0010, 32'h5100_FFFE);
    vecs[8]  = mkv(1'b0, 1'b1, 1'b0, 4'h0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0010, 32'h5100_FFFE);
    vecs[9]  = mkv(1'b0, 1'b1, 1'b0, 4'h1, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h000E, 32'h5100_FFFE);
    vecs[10] = mkv(1'b1, 1'b0, 1'b0, 4'h0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 16'h000E, 16'h000E, 32'h5100_FFFE);
    vecs[11] = mkv(1'b1, 1'b1, 1'b0, 4'h1, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 16'h000E, 16'h000E, 32'h5100_FFFE);
    vecs[12] = mkv(1'b0, 1'b0, 1'b1, 4'h0, 32'h6100_0040, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h000F, 32'h6100_0040);
    vecs[13] = mkv(1'b1, 1'b1, 1'b0, 4'h0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 16'h0040, 16'h0040, 32'h6100_0040);
    vecs[14] = mkv(1'b0, 1'b0, 1'b1, 4'h0, 32'h4000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0041, 32'h4000_0000);
    vecs[15] = mkv(1'b0, 1'b1, 1'b0, 4'hF, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0041, 32'h4000_0000);
    vecs[16] = mkv(1'b0, 1'b0, 1'b1, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0041, 32'h4000_0000);
    vecs[17] = mkv(1'b1, 1'b0, 1'b0, 4'h0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 16'h0041, 16'h0041, 32'h4000_0000);
    vecs[18] = mkv(1'b0, 1'b0, 1'b1, 4'h0, 32'h4F00_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0042, 32'h4F00_FFFF);
    vecs[19] = mkv(1'b0, 1'b1, 1'b0, 4'h1, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 32'h4F00_FFFF);
    vecs[20] = mkv(1'b1, 1'b0, 1'b0, 4'h0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 32'h4F00_FFFF);
    vecs[21] = mkv(1'b0, 1'b0, 1'b1, 4'h0, 32'h8F00_0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 32'h8F00_0000);
    vecs[22] = mkv(1'b0, 1'b1, 1'b0, 4'hF, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 32'h8F00_0000);

    idle_inputs();
    rst_f = 1'b1;
    tick();
    tick();
    rst_f = 1'b0;
    chk("reset_state", obs(), 73'h0);

    for (int i = 0; i < NV; i++) begin
      ir_load  = vecs[i].il;
      pc_write = vecs[i].pw;
      im_valid = vecs[i].v;
      stat     = vecs[i].st;
      im_rdata = vecs[i].rdata;
      tick();
      chk($sformatf("vec%0d", i), obs(), expv(vecs[i]));
    end
    idle_inputs();

    // Three wait cycles with a stray ir_load mid-fetch; PC starts at 0x0000.
    ir_load  = 1'b1;
    tick();
    reqs     = 0;
    prev_req = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("wait_fd_c%0d", c), 73'(fetch_done), 73'(c == 5));
      if (im_req && !prev_req) reqs++;
      prev_req = im_req;
      ir_load  = (c == 2);
      im_valid = (c == 4);
      im_rdata = 32'h1234_5678;
      tick();
    end
    idle_inputs();
    chk("wait_one_request", 73'(reqs), 73'(1));
    chk("wait_pc", 73'(pc), 73'(16'h0001));
    chk("wait_ir", 73'({opcode, mm, rd, rs, imm}), 73'(32'h1234_5678));

    // Reset in the middle of a fetch, then a stale response in IDLE.
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    chk("rst_pre_busy", 73'(busy), 73'(1'b1));
    rst_f = 1'b1;
    tick();
    rst_f = 1'b0;
    chk("rst_midfetch", obs(), 73'h0);
    im_valid = 1'b1;
    im_rdata = 32'hCAFE_F00D;
    tick();
    idle_inputs();
    chk("rst_stale_valid", obs(), 73'h0);
    tick();
    chk("rst_stale_nofd", obs(), 73'h0);

    // HLT word fetch.
    ir_load = 1'b1;
    tick();
    ir_load  = 1'b0;
    im_valid = 1'b1;
    im_rdata = 32'hF000_0000;
    tick();
    idle_inputs();
    chk("hlt_fd", 73'(fetch_done), 73'(1'b1));
`ifdef SISC_HALT_DETECT_EN
    chk("hlt_halted", 73'(halted), 73'(1'b1));
`else
    chk("hlt_halted", 73'(halted), 73'(1'b0));
`endif
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
`ifdef SISC_HALT_DETECT_EN
    chk("hlt_no_req", 73'(im_req), 73'(1'b0));
    tick();
    chk("hlt_still", 73'({im_req, halted}), 73'(2'b01));
`else
    chk("hlt_req", 73'(im_req), 73'(1'b1));
    im_valid = 1'b1;
    tick();
    idle_inputs();
    chk("hlt_refetch_pc", 73'(pc), 73'(16'h0002));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
